// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for sync_stream_fifo.
//   ptr_w     - pointer width for a given entry count
//   cnt_w     - occupancy counter width ($clog2(DEPTH+1))
//   ptr_inc   - pointer increment with explicit wrap at DEPTH-1
//   calc_flags- full/empty/almost flags for a given occupancy
package fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Explicit wrap so that non-power-of-two depths never index past DEPTH-1.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

   function automatic fifo_flags_t calc_flags(input int unsigned cnt,
                                              input int unsigned depth,
                                              input int unsigned af_level,
                                              input int unsigned ae_level);
      fifo_flags_t f;
      f.full         = (cnt == depth);
      f.empty        = (cnt == 0);
      f.almost_full  = (cnt >= af_level);
      f.almost_empty = (cnt <= ae_level);
      return f;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register-array storage for sync_stream_fifo.
// One synchronous write port, one asynchronous read port. Contents are never reset.
//   CLK     - clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - read data (combinational from i_raddr)
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 32
) (
   input  logic                      CLK,
   input  logic                      i_we,
   input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
   input  logic [DATA_W-1:0]         i_wdata,
   input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
   output logic [DATA_W-1:0]         o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_stream_fifo.sv
// sync_stream_fifo: single-clock first-word-fall-through stream FIFO.
// Build option: define FIFO_CLEAR_EN to add the CLEAR synchronous flush port.
//   CLK          - clock, rising edge
//   RESETN       - synchronous active-low reset
//   CLEAR        - synchronous flush (FIFO_CLEAR_EN only), beats push/pop
//   S_VALID/S_READY/S_DATA - write side; S_READY = !full
//   M_VALID/M_READY/M_DATA - read side; M_VALID = !empty, M_DATA = head entry
//   COUNT        - occupancy
//   ALMOST_FULL  - COUNT >= AF_LEVEL (registered)
//   ALMOST_EMPTY - COUNT <= AE_LEVEL (registered)
module sync_stream_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2
) (
   input  logic                       CLK,
   input  logic                       RESETN,
`ifdef FIFO_CLEAR_EN
   input  logic                       CLEAR,
`endif
   input  logic                       S_VALID,
   output logic                       S_READY,
   input  logic [DATA_W-1:0]          S_DATA,
   output logic                       M_VALID,
   input  logic                       M_READY,
   output logic [DATA_W-1:0]          M_DATA,
   output logic [$clog2(DEPTH+1)-1:0] COUNT,
   output logic                       ALMOST_FULL,
   output logic                       ALMOST_EMPTY
);

   localparam int unsigned PtrW = ptr_w(DEPTH);
   localparam int unsigned CntW = cnt_w(DEPTH);

   logic [PtrW-1:0] r_head, r_tail;
   logic [CntW-1:0] r_count;
   fifo_flags_t     r_flags;

   logic [PtrW-1:0] w_head_d, w_tail_d;
   logic [CntW-1:0] w_count_d;
   fifo_flags_t     w_flags_d;
   fifo_flags_t     w_flags_rst;
   logic            w_push, w_pop, w_flush;

`ifdef FIFO_CLEAR_EN
   assign w_flush = !RESETN || CLEAR;
`else
   assign w_flush = !RESETN;
`endif

   // Handshakes depend only on registered flags: no M_READY -> S_READY path.
   assign S_READY = !r_flags.full;
   assign M_VALID = !r_flags.empty;
   assign w_push  = S_VALID && S_READY;
   assign w_pop   = M_VALID && M_READY;

   always_comb begin
      w_head_d  = r_head;
      w_tail_d  = r_tail;
      w_count_d = r_count;
      if (w_push) begin
         w_tail_d = PtrW'(ptr_inc(32'(r_tail), DEPTH));
      end
      if (w_pop) begin
         w_head_d = PtrW'(ptr_inc(32'(r_head), DEPTH));
      end
      unique case ({w_push, w_pop})
         2'b10:   w_count_d = r_count + CntW'(1);
         2'b01:   w_count_d = r_count - CntW'(1);
         default: w_count_d = r_count;
      endcase
   end

   // Flags follow next-state COUNT so they line up with COUNT after the edge.
   assign w_flags_d   = calc_flags(32'(w_count_d), DEPTH, AF_LEVEL, AE_LEVEL);
   assign w_flags_rst = calc_flags(0, DEPTH, AF_LEVEL, AE_LEVEL);

   always_ff @(posedge CLK) begin
      if (w_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_flags <= w_flags_rst;
      end else begin
         r_head  <= w_head_d;
         r_tail  <= w_tail_d;
         r_count <= w_count_d;
         r_flags <= w_flags_d;
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .CLK     (CLK),
      .i_we    (w_push && !w_flush),
      .i_waddr (r_tail),
      .i_wdata (S_DATA),
      .i_raddr (r_head),
      .o_rdata (M_DATA)
   );

   assign COUNT        = r_count;
   assign ALMOST_FULL  = r_flags.almost_full;
   assign ALMOST_EMPTY = r_flags.almost_empty;

endmodule

// File: doc/sync_stream_fifo.md
SYNC_STREAM_FIFO -- requirements
Module: sync_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_W, 32, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, 32, entry count (>=2; need not be a power of two).
REQ-003 SHALL have parameter AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when COUNT >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, 2, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL.
REQ-005 SHALL have port CLK  in  1  clock; all logic on its rising edge.
REQ-006 SHALL have port RESETN  in  1  synchronous, active-low reset.
REQ-007 SHALL have port S_VALID  in  1  write-side data valid.
REQ-008 SHALL have port S_READY  out  1  write-side ready, equal to !full.
REQ-009 SHALL have port S_DATA  in  DATA_W  write data.
REQ-010 SHALL have port M_VALID  out  1  read-side data valid, equal to !empty.
REQ-011 SHALL have port M_READY  in  1  read-side ready.
REQ-012 SHALL have port M_DATA  out  DATA_W  head-of-queue data (first-word-fall-through).
REQ-013 SHALL have port COUNT  out  $clog2(DEPTH+1)  current occupancy.
REQ-014 SHALL have port ALMOST_FULL  out  1  registered almost-full flag.
REQ-015 SHALL have port ALMOST_EMPTY  out  1  registered almost-empty flag.
REQ-016 SHALL have port CLEAR  in  1  synchronous flush; present only under FIFO_CLEAR_EN.

Function
REQ-017 SHALL define push = S_VALID & S_READY and pop = M_VALID & M_READY; only these change state.
REQ-018 SHALL write S_DATA into the tail entry and advance the tail pointer on push.
REQ-019 SHALL advance the head pointer on pop; M_DATA SHALL show the new head in the following cycle.
REQ-020 SHALL wrap each pointer from DEPTH-1 to 0 explicitly, so non-power-of-two DEPTH works.
REQ-021 SHALL make written data visible on M_DATA/M_VALID one cycle after push; there is no empty-bypass path.
REQ-022 SHALL update COUNT as: +1 on push only, -1 on pop only, unchanged on push&pop or on neither.
REQ-023 SHALL, on simultaneous push and pop with 0 < COUNT < DEPTH, move both pointers and hold COUNT.
REQ-024 SHALL deassert S_READY when full (COUNT==DEPTH), with no combinational path from M_READY; push is blocked in that cycle even if pop occurs.
REQ-025 SHALL hold M_VALID low when empty; M_READY is then ignored and the pointers do not move.
REQ-026 SHALL hold M_DATA stable while M_VALID=1 and no pop occurs.
REQ-027 SHALL derive full, empty, ALMOST_FULL and ALMOST_EMPTY from next-state COUNT and register them, so all are valid in the same cycle as COUNT.
REQ-028 SHALL leave storage contents unchanged when there is no push.

Reset
REQ-029 SHALL, while RESETN=0 at a clock edge, set head=0, tail=0, COUNT=0, M_VALID=0, S_READY=1, ALMOST_EMPTY=1, and ALMOST_FULL=(AF_LEVEL==0).
REQ-030 SHALL NOT reset the storage array; M_DATA is don't-care while M_VALID=0.
REQ-031 SHALL discard any push or pop in the reset cycle, including a reset asserted mid-stream.

Configuration
REQ-032 SHALL, with FIFO_CLEAR_EN defined, provide the CLEAR port; CLEAR=1 at a clock edge behaves as reset for pointers, COUNT and flags, and takes priority over push and pop.
REQ-033 SHALL, without FIFO_CLEAR_EN, have no CLEAR port and no clear logic.

Structure
REQ-034 SHALL place the pointer-increment-with-wrap function and the count-width helper in package fifo_pkg.
REQ-035 SHALL instantiate sub-module fifo_mem (register array with one write port and one asynchronous read port, parameters DATA_W and DEPTH); all control logic stays in sync_stream_fifo.

Verification
REQ-036 Fill: DEPTH=4; push 0xA1..0xA4 with M_READY=0 -> COUNT=4, S_READY=0, ALMOST_FULL=1; a fifth S_VALID is not accepted.
REQ-037 Drain: from the full state, M_READY=1 for 4 cycles -> M_DATA=0xA1,0xA2,0xA3,0xA4 in order; then M_VALID=0, COUNT=0, ALMOST_EMPTY=1.
REQ-038 Wrap: DEPTH=5; 12 push/pop pairs at COUNT=2 -> data in order, COUNT stays 2, pointers wrap 4 to 0.
REQ-039 Full corner: DEPTH=4 full, S_VALID=1 and M_READY=1 -> pop only, COUNT=3; push accepted in the next cycle.
REQ-040 Reset mid-stream: COUNT=3, RESETN=0 for 1 cycle -> COUNT=0, M_VALID=0, S_READY=1; the next push of 0x55 appears on M_DATA one cycle later.
REQ-041 Clear (FIFO_CLEAR_EN): COUNT=2, CLEAR=1 with S_VALID=1 -> COUNT=0 and the pushed word is discarded.
